// File: rtl/spike_aer_queue.sv
// spike_aer_queue
// Spike output stage behind config memory port B. Fire events (neuron ids)
// are queued. Each id is turned into a SpikeAER word by a request/grant read
// of port B. The words are buffered in a first-word-fall-through FIFO that
// feeds the NoC router injection port over valid/ready.
//
// Optional feature: define SPIKE_AER_NULL_DROP_EN to discard all-zero
// fetched words (unconnected neurons). Each discarded word is counted in
// null_drop_cnt_o, a 16-bit saturating counter.
module spike_aer_queue #(
    parameter int NURN_CNT_BIT_WIDTH = 8,
    parameter int AER_BIT_WIDTH      = 32,
    parameter int ID_FIFO_DEPTH      = 8,
    parameter int AER_FIFO_DEPTH     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          fire_i,
    input  logic [NURN_CNT_BIT_WIDTH-1:0] nurn_id_i,
    output logic                          cfg_req_o,
    input  logic                          cfg_gnt_i,
    output logic [NURN_CNT_BIT_WIDTH-1:0] cfg_addr_o,
    output logic                          cfg_rdEn_o,
    input  logic [AER_BIT_WIDTH-1:0]      cfg_spikeAER_i,
    output logic                          aer_valid_o,
    output logic [AER_BIT_WIDTH-1:0]      aer_data_o,
    input  logic                          aer_ready_i,
    output logic                          busy_o,
`ifdef SPIKE_AER_NULL_DROP_EN
    output logic [15:0]                   null_drop_cnt_o,
`endif
    output logic                          ovf_o
);

    localparam int IDW = $clog2(ID_FIFO_DEPTH);
    localparam int AEW = $clog2(AER_FIFO_DEPTH);
    localparam logic [IDW:0] ID_PTR_ONE  = (IDW+1)'(1);
    localparam logic [AEW:0] AER_PTR_ONE = (AEW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Fire-event (id) FIFO. Pointers carry one extra wrap bit to tell full from empty.
    logic [NURN_CNT_BIT_WIDTH-1:0] id_mem_q [ID_FIFO_DEPTH];
    logic [IDW:0] id_wr_q, id_wr_d, id_rd_q, id_rd_d;
    logic         id_empty_s, id_full_s, id_push_s, id_pop_s;
    logic         ovf_q, ovf_d;

    // AER word FIFO, first-word-fall-through
    logic [AER_BIT_WIDTH-1:0] aer_mem_q [AER_FIFO_DEPTH];
    logic [AEW:0] aer_wr_q, aer_wr_d, aer_rd_q, aer_rd_d;
    logic         aer_empty_s, aer_full_s, aer_push_s, aer_pop_s;

`ifdef SPIKE_AER_NULL_DROP_EN
    logic         null_drop_s;
    logic [15:0]  drop_cnt_q, drop_cnt_d;
`endif

    // ID FIFO status, push/pop decisions and sticky overflow next-state
    always_comb begin
        id_empty_s = (id_wr_q == id_rd_q);
        id_full_s  = (id_wr_q[IDW] != id_rd_q[IDW]) &&
                     (id_wr_q[IDW-1:0] == id_rd_q[IDW-1:0]);
        // A granted read consumes the head id
        id_pop_s   = (state_q == ST_REQ) && cfg_gnt_i;
        // A full queue still takes a new id when the head leaves in the same cycle
        id_push_s  = fire_i && (!id_full_s || id_pop_s);
        if (id_push_s) begin
            id_wr_d = id_wr_q + ID_PTR_ONE;
        end else begin
            id_wr_d = id_wr_q;
        end
        if (id_pop_s) begin
            id_rd_d = id_rd_q + ID_PTR_ONE;
        end else begin
            id_rd_d = id_rd_q;
        end
        ovf_d = ovf_q | (fire_i & id_full_s & ~id_pop_s);
    end

    // AER FIFO status and push/pop decisions (optional null-word filter)
    always_comb begin
        aer_empty_s = (aer_wr_q == aer_rd_q);
        aer_full_s  = (aer_wr_q[AEW] != aer_rd_q[AEW]) &&
                      (aer_wr_q[AEW-1:0] == aer_rd_q[AEW-1:0]);
`ifdef SPIKE_AER_NULL_DROP_EN
        null_drop_s = (state_q == ST_WAIT) &&
                      (cfg_spikeAER_i == {AER_BIT_WIDTH{1'b0}});
        aer_push_s  = (state_q == ST_WAIT) && !null_drop_s;
        if (null_drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
`else
        aer_push_s  = (state_q == ST_WAIT);
`endif
        aer_pop_s   = !aer_empty_s && aer_ready_i;
        if (aer_push_s) begin
            aer_wr_d = aer_wr_q + AER_PTR_ONE;
        end else begin
            aer_wr_d = aer_wr_q;
        end
        if (aer_pop_s) begin
            aer_rd_d = aer_rd_q + AER_PTR_ONE;
        end else begin
            aer_rd_d = aer_rd_q;
        end
    end

    // Fetch FSM next state: start a read only if there is room for its result
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!id_empty_s && !aer_full_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (cfg_gnt_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointers and flags; reset drops queued ids, buffered words and any read in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            id_wr_q  <= {(IDW+1){1'b0}};
            id_rd_q  <= {(IDW+1){1'b0}};
            aer_wr_q <= {(AEW+1){1'b0}};
            aer_rd_q <= {(AEW+1){1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_wr_q  <= id_wr_d;
            id_rd_q  <= id_rd_d;
            aer_wr_q <= aer_wr_d;
            aer_rd_q <= aer_rd_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef SPIKE_AER_NULL_DROP_EN
    // Saturating count of discarded all-zero words
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign null_drop_cnt_o = drop_cnt_q;
`endif

    // ID storage; contents need no reset because the pointers qualify them
    always_ff @(posedge clk_i) begin
        if (id_push_s) begin
            id_mem_q[id_wr_q[IDW-1:0]] <= nurn_id_i;
        end
    end

    // AER word storage; the memory output is captured the cycle after the granted read
    always_ff @(posedge clk_i) begin
        if (aer_push_s) begin
            aer_mem_q[aer_wr_q[AEW-1:0]] <= cfg_spikeAER_i;
        end
    end

    // Outputs come from registered state. Address and data read zero when not meaningful.
    always_comb begin
        cfg_req_o   = (state_q == ST_REQ);
        cfg_rdEn_o  = cfg_req_o & cfg_gnt_i;
        if (cfg_req_o) begin
            cfg_addr_o = id_mem_q[id_rd_q[IDW-1:0]];
        end else begin
            cfg_addr_o = {NURN_CNT_BIT_WIDTH{1'b0}};
        end
        aer_valid_o = !aer_empty_s;
        if (aer_valid_o) begin
            aer_data_o = aer_mem_q[aer_rd_q[AEW-1:0]];
        end else begin
            aer_data_o = {AER_BIT_WIDTH{1'b0}};
        end
        busy_o = !id_empty_s || (state_q != ST_IDLE) || !aer_empty_s;
        ovf_o  = ovf_q;
    end

endmodule

// File: tb/tb_spike_aer_queue.sv
// Bench for spike_aer_queue. A queue-based reference model predicts every
// output on every cycle. Directed scenarios pin the latencies and orderings
// with literal values. A long randomized run follows.
module tb_spike_aer_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fire = 1'b0;
    logic [7:0]  nurn = 8'd0;
    logic        gnt = 1'b1;
    logic        ready = 1'b1;
    logic [31:0] mem_q = 32'd0;
    logic        cfg_req_o, cfg_rdEn_o, aer_valid_o, busy_o, ovf_o;
    logic [7:0]  cfg_addr_o;
    logic [31:0] aer_data_o;
`ifdef SPIKE_AER_NULL_DROP_EN
    logic [15:0] null_drop_cnt_o;
`endif

    always #5 clk = ~clk;

    spike_aer_queue dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .fire_i         (fire),
        .nurn_id_i      (nurn),
        .cfg_req_o      (cfg_req_o),
        .cfg_gnt_i      (gnt),
        .cfg_addr_o     (cfg_addr_o),
        .cfg_rdEn_o     (cfg_rdEn_o),
        .cfg_spikeAER_i (mem_q),
        .aer_valid_o    (aer_valid_o),
        .aer_data_o     (aer_data_o),
        .aer_ready_i    (ready),
`ifdef SPIKE_AER_NULL_DROP_EN
        .null_drop_cnt_o(null_drop_cnt_o),
`endif
        .busy_o         (busy_o),
        .ovf_o          (ovf_o)
    );

    bit null_mode = 1'b0;

    // Contents of the config memory
    function automatic logic [31:0] word_of(input logic [7:0] id);
        if (null_mode) begin
            if (id == 8'd2) return 32'h0000_0011;
            return 32'h0000_0000;
        end
        return {16'hA5A5, 8'h00, id};
    endfunction

    // Registered memory read port. When no read is enabled it outputs junk,
    // so sampling the wrong cycle corrupts the captured word.
    always @(posedge clk) begin
        if (cfg_rdEn_o) mem_q <= word_of(cfg_addr_o);
        else            mem_q <= $urandom;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_stage: 0 = no fetch, 1 = requesting the head id, 2 = memory word returning
    logic [7:0]  m_idq[$];
    logic [31:0] m_outq[$];
    int          m_stage = 0;
    logic [7:0]  m_fetch = 8'd0;
    bit          m_ovf = 1'b0;
    int          m_drops = 0;
    bit          m_pop, m_take, m_start;
    logic [31:0] m_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idq.delete();
            m_outq.delete();
            m_stage = 0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            m_pop   = (m_stage == 1) && gnt;
            m_take  = (m_idq.size() < 8) || m_pop;
            m_start = (m_idq.size() > 0) && (m_outq.size() < 4);
            if (m_outq.size() > 0 && ready) void'(m_outq.pop_front());
            case (m_stage)
                0: if (m_start) m_stage = 1;
                1: if (gnt) begin m_fetch = m_idq.pop_front(); m_stage = 2; end
                default: begin
                    m_w = word_of(m_fetch);
`ifdef SPIKE_AER_NULL_DROP_EN
                    if (m_w == 32'd0) begin
                        if (m_drops < 65535) m_drops++;
                    end else m_outq.push_back(m_w);
`else
                    m_outq.push_back(m_w);
`endif
                    m_stage = 0;
                end
            endcase
            if (fire) begin
                if (m_take) m_idq.push_back(nurn);
                else        m_ovf = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        check("cfg_req_o",   cfg_req_o,   (m_stage == 1));
        check("cfg_rdEn_o",  cfg_rdEn_o,  (m_stage == 1) && gnt);
        if (m_stage == 1) check("cfg_addr_o", cfg_addr_o, m_idq[0]);
        else if (!rst_n)  check("cfg_addr_o_rst", cfg_addr_o, 8'd0);
        check("aer_valid_o", aer_valid_o, m_outq.size() > 0);
        if (m_outq.size() > 0) check("aer_data_o", aer_data_o, m_outq[0]);
        else if (!rst_n)       check("aer_data_o_rst", aer_data_o, 32'd0);
        check("busy_o", busy_o, (m_idq.size() > 0) || (m_stage != 0) || (m_outq.size() > 0));
        check("ovf_o",  ovf_o,  m_ovf);
`ifdef SPIKE_AER_NULL_DROP_EN
        check("null_drop_cnt_o", null_drop_cnt_o, m_drops);
`endif
    end

    // Words accepted by the router
    logic [31:0] got_q[$];
    always @(posedge clk) begin
        if (rst_n && aer_valid_o && ready) got_q.push_back(aer_data_o);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (busy_o && k < budget) begin
            tick();
            k++;
        end
        check("drain_done", busy_o, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        bit found;
        // ---------- reset ----------
        repeat (3) tick();
        check("rst_req",   cfg_req_o,   1'b0);
        check("rst_valid", aer_valid_o, 1'b0);
        check("rst_data",  aer_data_o,  32'd0);
        check("rst_busy",  busy_o,      1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        // ---------- single fire: valid at cycle 4 ----------
        got_q.delete();
        fire = 1'b1; nurn = 8'h05; first = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) fire = 1'b0;
            if (aer_valid_o && first < 0) begin
                first = k;
                check("t1_data", aer_data_o, 32'hA5A5_0005);
            end
            if (k == 5) check("t1_busy_fall", busy_o, 1'b0);
        end
        check("t1_latency", first, 4);

        // ---------- grant stall: 3 denied cycles -> valid at cycle 7 ----------
        gnt = 1'b0; fire = 1'b1; nurn = 8'h05; first = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) fire = 1'b0;
            if (k >= 2 && k <= 4) begin
                check("t2_addr_stable", cfg_addr_o, 8'h05);
                check("t2_no_rden", cfg_rdEn_o, 1'b0);
            end
            if (k == 5) gnt = 1'b1;
            if (aer_valid_o && first < 0) first = k;
        end
        check("t2_latency", first, 7);
        drain(20);

        // ---------- back-pressure ----------
        ready = 1'b0; gnt = 1'b1; got_q.delete();
        fire = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nurn = 8'(i);
            tick();
        end
        fire = 1'b0;
        repeat (30) tick();
        check("t3_parked", cfg_req_o, 1'b0);
        check("t3_valid",  aer_valid_o, 1'b1);
        check("t3_model_ids", m_idq.size(), 2);
        check("t3_model_words", m_outq.size(), 4);
        ready = 1'b1;
        drain(100);
        check("t3_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            check("t3_order", got_q[i], 32'hA5A5_0000 | 32'(i));
        check("t3_ovf", ovf_o, 1'b0);

        // ---------- overflow ----------
        gnt = 1'b0; got_q.delete();
        fire = 1'b1;
        for (int i = 0; i < 9; i++) begin
            nurn = 8'(i);
            tick();
            if (i == 7) check("t4_ovf_before", ovf_o, 1'b0);
            if (i == 8) check("t4_ovf_after",  ovf_o, 1'b1);
        end
        fire = 1'b0;
        check("t4_model_ids", m_idq.size(), 8);
        repeat (3) tick();
        gnt = 1'b1;
        drain(200);
        check("t4_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check("t4_order", got_q[i], 32'hA5A5_0000 | 32'(i));
        check("t4_ovf_sticky", ovf_o, 1'b1);

        // ---------- reset in WAIT with 3 words buffered ----------
        ready = 1'b0; gnt = 1'b1; got_q.delete();
        fire = 1'b1;
        for (int i = 10; i < 14; i++) begin
            nurn = 8'(i);
            tick();
        end
        fire = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (m_stage == 2 && m_outq.size() == 3) found = 1'b1;
            else tick();
        end
        check("t5_reached_wait", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_req",   cfg_req_o,   1'b0);
        check("t5_rden",  cfg_rdEn_o,  1'b0);
        check("t5_addr",  cfg_addr_o,  8'd0);
        check("t5_valid", aer_valid_o, 1'b0);
        check("t5_data",  aer_data_o,  32'd0);
        check("t5_busy",  busy_o,      1'b0);
        check("t5_ovf",   ovf_o,       1'b0);
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (10) tick();
        check("t5_nothing_out", got_q.size(), 0);

`ifdef SPIKE_AER_NULL_DROP_EN
        // ---------- null-word drop ----------
        null_mode = 1'b1; got_q.delete();
        fire = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            nurn = 8'(i);
            tick();
        end
        fire = 1'b0;
        drain(50);
        repeat (2) tick();
        check("t6_count", got_q.size(), 1);
        if (got_q.size() > 0) check("t6_word", got_q[0], 32'h0000_0011);
        check("t6_drops", null_drop_cnt_o, 16'd2);
        null_mode = 1'b0;
`endif

        // ---------- randomized traffic ----------
        for (int k = 0; k < 3000; k++) begin
            int fp;
            fp    = (k < 1500) ? 30 : 70;
            fire  = ($urandom_range(0, 99) < fp);
            nurn  = 8'($urandom);
            gnt   = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 3) != 0) || (k >= 2000 && k < 2300 ? 1'b0 : 1'b0);
            if (k >= 2000 && k < 2300) ready = ($urandom_range(0, 7) == 0);
            tick();
        end
        fire = 1'b0; gnt = 1'b1; ready = 1'b1;
        drain(500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spike_aer_queue.md
# spike_aer_queue

Spike output stage placed directly downstream of the neuron configuration memory's read port B. It accepts fire events (neuron index) from the neuron controller and fetches each neuron's destination SpikeAER word through config port B under a request/grant handshake. It buffers the resulting AER words and presents them to the NoC router injection port over valid/ready.

## Interface
Parameters:
- NURN_CNT_BIT_WIDTH, 8, neuron index width (config port B address width)
- AER_BIT_WIDTH, 32, SpikeAER word width
- ID_FIFO_DEPTH, 8, fire-event queue depth (power of 2, ≥2)
- AER_FIFO_DEPTH, 4, AER output queue depth (power of 2, ≥2)

Ports:
- clk_i  in  1  single clock, all logic on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- fire_i  in  1  one-cycle fire strobe from neuron controller
- nurn_id_i  in  NURN_CNT_BIT_WIDTH  index of firing neuron, sampled with fire_i
- cfg_req_o  in/out: out  1  request for config port B
- cfg_gnt_i  in  1  arbiter grant for port B, valid in same cycle as cfg_req_o
- cfg_addr_o  out  NURN_CNT_BIT_WIDTH  port B address (drives Addr_Config_B_i when granted)
- cfg_rdEn_o  out  1  port B read enable, = cfg_req_o & cfg_gnt_i
- cfg_spikeAER_i  in  AER_BIT_WIDTH  SpikeAER_o from config memory (registered output)
- aer_valid_o  out  1  AER word available
- aer_data_o  out  AER_BIT_WIDTH  AER word to router
- aer_ready_i  in  1  router accepts word when aer_valid_o & aer_ready_i
- busy_o  out  1  any event queued, in flight, or buffered
- ovf_o  out  1  sticky: fire event lost to full ID FIFO

## Operation
- ID FIFO: fire_i pushes nurn_id_i. Push while full and no same-cycle pop: event dropped, ovf_o set; ovf_o clears only on reset. Push while full with a same-cycle pop: accepted.
- FSM states: IDLE, REQ, WAIT.
- IDLE -> REQ when ID FIFO non-empty and AER FIFO not full; otherwise stay.
- REQ: cfg_req_o=1, cfg_addr_o=ID FIFO head. If cfg_gnt_i=1: pop head, go WAIT. Else hold REQ with address stable.
- WAIT: cfg_spikeAER_i is valid. Push into AER FIFO, go IDLE.
- At most one read in flight. The AER FIFO cannot be full in WAIT, because pushes occur only in WAIT.
- AER FIFO: FWFT. aer_data_o = head while aer_valid_o. Pop on aer_valid_o & aer_ready_i. Push and pop in the same cycle is legal at any occupancy.
- Data in aer_data_o holds stable while aer_valid_o & !aer_ready_i.
- busy_o = ID FIFO non-empty | state≠IDLE | AER FIFO non-empty.
- Reset mid-operation: both FIFOs emptied, FSM to IDLE, any granted read discarded.
- Reset values: cfg_req_o 0, cfg_rdEn_o 0, cfg_addr_o 0, aer_valid_o 0, aer_data_o 0, busy_o 0, ovf_o 0.

## Timing
- Fire at cycle 0 into an empty, idle block:
  - cycle 1: FSM in IDLE, FIFO non-empty.
  - cycle 2: REQ with cfg_rdEn_o=1 (grant assumed).
  - cycle 3: WAIT, capture.
  - cycle 4: aer_valid_o=1.
- Latency is 4 cycles plus one cycle per denied grant.
- Sustained throughput is one spike per 3 cycles.
- cfg_spikeAER_i is sampled exactly one cycle after the granted cfg_rdEn_o.

## Configuration
- SPIKE_AER_NULL_DROP_EN:
  - Defined: in WAIT, a fetched word equal to all zeros (unconnected neuron) is not pushed, and the FSM returns to IDLE. A 16-bit saturating counter, null_drop_cnt_o (extra output port, reset 0), increments per drop.
  - Undefined: all fetched words are pushed, and the port is absent.

## Test plan
- Single fire: nurn_id_i=0x05, mem word 0xA5A5_0005, gnt and ready tied 1 -> aer_valid_o rises cycle 4 with 0xA5A5_0005; busy_o falls after pop.
- Grant stall: gnt held 0 for 3 cycles in REQ -> cfg_addr_o stable at 0x05, no pop; aer_valid_o at cycle 7.
- Back-pressure: ready=0, 6 fires (ids 0..5) -> AER FIFO holds 4 and the FSM parks in IDLE with 2 IDs queued. Then ready=1 -> 6 words out in id order; ovf_o stays 0.
- Overflow: 9 back-to-back fires with gnt=0 -> 8 queued, ovf_o=1 from the 9th; later release delivers ids 0..7 only.
- Reset mid-flight: assert rst_n_i in WAIT with 3 words buffered -> all outputs return to reset values at once; no word emitted after release.
- With SPIKE_AER_NULL_DROP_EN: ids 1,2,3 with words 0x0, 0x11, 0x0 -> only 0x11 emitted; null_drop_cnt_o=2.
